// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute/writeback pipeline register behind the 16-bit ALU.
// Holds one writeback bundle under a valid/ready handshake, owns the
// architectural condition-code register {S,Z,C,V}, resolves conditional
// branches against the committed flags and counts retired bundles.
module ex_wb_stage #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_cond,
  input  logic [RA_W-1:0]   rd_addr,
  input  logic              wb_req,
  input  logic              set_cc,
  input  logic              is_branch,
  input  logic [2:0]        br_cond,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [RA_W-1:0]   wb_addr,
  output logic              wb_en,
  output logic              br_taken,
  output logic [3:0]        flags,
  output logic [CNT_W-1:0]  retired
);

  logic              out_valid_reg;
  logic [DATA_W-1:0] wb_data_reg;
  logic [RA_W-1:0]   wb_addr_reg;
  logic              wb_en_reg;
  logic              br_taken_reg;
  logic [3:0]        flags_reg;
  logic [CNT_W-1:0]  retired_reg;
  logic [CNT_W-1:0]  retired_next;

  logic accept;
  logic consume;
  logic flag_s;
  logic flag_z;
  logic flag_v;
  logic cond_true;
  logic [7:0] cond_table;

  // Committed flags feed the branch decision; the carry bit plays no part
  // in any supported condition.
  assign flag_s = flags_reg[3];
  assign flag_z = flags_reg[2];
  assign flag_v = flags_reg[0];

  // One entry per branch condition code, all evaluated against the flags
  // as they stand before the current edge (a compare never steers itself).
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_cond
      if (gi == 0) begin : g_be
        assign cond_table[gi] = flag_z;
      end else if (gi == 1) begin : g_blt
        assign cond_table[gi] = flag_s ^ flag_v;
      end else if (gi == 2) begin : g_ble
        assign cond_table[gi] = flag_z | (flag_s ^ flag_v);
      end else if (gi == 3) begin : g_bne
        assign cond_table[gi] = ~flag_z;
      end else if (gi == 4) begin : g_b
        assign cond_table[gi] = 1'b1;
      end else begin : g_never
        assign cond_table[gi] = 1'b0;
      end
    end
  endgenerate

  assign cond_true = cond_table[br_cond];

  // Single-entry stage: room when empty or when the held bundle leaves now;
  // a flush closes the door on the incoming instruction.
  assign in_ready = (~out_valid_reg | out_ready) & ~flush;
  assign accept   = in_valid & in_ready;
  assign consume  = out_valid_reg & out_ready;

  // Saturating increment: once all-ones the counter stays there.
  assign retired_next = (&retired_reg) ? retired_reg
                                       : retired_reg + {{(CNT_W-1){1'b0}}, 1'b1};

  // Pipeline register, flags and retire counter; reset beats flush beats accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      wb_data_reg   <= '0;
      wb_addr_reg   <= '0;
      wb_en_reg     <= 1'b0;
      br_taken_reg  <= 1'b0;
      flags_reg     <= 4'b0000;
      retired_reg   <= '0;
    end else begin
      // Downstream has already taken the bundle, so count it even under flush.
      if (consume) begin
        retired_reg <= retired_next;
      end
      if (flush) begin
        out_valid_reg <= 1'b0;
        wb_en_reg     <= 1'b0;
        br_taken_reg  <= 1'b0;
      end else if (accept) begin
        out_valid_reg <= 1'b1;
        wb_data_reg   <= alu_out;
        wb_addr_reg   <= rd_addr;
        wb_en_reg     <= wb_req;
        br_taken_reg  <= is_branch & cond_true;
        if (set_cc) begin
          flags_reg <= alu_cond;
        end
      end else if (consume) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign wb_data   = wb_data_reg;
  assign wb_addr   = wb_addr_reg;
  assign wb_en     = wb_en_reg;
  assign br_taken  = br_taken_reg;
  assign flags     = flags_reg;
  assign retired   = retired_reg;

endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Execute/writeback pipeline register placed directly downstream of the 16-bit ALU.
- Captures the ALU result and its 4-bit condition vector (S,Z,C,V) and holds the architectural condition-code register.
- Evaluates conditional branches against the committed flags and presents a registered writeback bundle to the register file under a valid/ready handshake.
- Supports flush and a saturating retire counter.

Parameters:
- DATA_W, 16, datapath width of the ALU result and writeback data.
- RA_W, 3, register-file address width.
- CNT_W, 16, retire counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- alu_out  in  DATA_W  ALU result.
- alu_cond  in  4  ALU condition vector: bit3 S, bit2 Z, bit1 C, bit0 V.
- rd_addr  in  RA_W  destination register.
- wb_req  in  1  instruction writes rd.
- set_cc  in  1  instruction updates flags.
- is_branch  in  1  instruction is a branch.
- br_cond  in  3  0 BE, 1 BLT, 2 BLE, 3 BNE, 4 B (always), 5–7 never.
- flush  in  1  kill the stage contents and the incoming instruction.
- out_valid  out  1  writeback bundle valid.
- out_ready  in  1  downstream consumes the bundle.
- wb_data  out  DATA_W  registered result.
- wb_addr  out  RA_W  registered destination.
- wb_en  out  1  registered write enable; qualified by out_valid.
- br_taken  out  1  registered branch decision; qualified by out_valid.
- flags  out  4  committed condition-code register {S,Z,C,V}.
- retired  out  CNT_W  count of bundles consumed downstream; saturates at all-ones.

Behaviour:
- Reset (rst_n low at clk edge):
  - out_valid, wb_en and br_taken are 0.
  - wb_data, wb_addr, flags and retired are 0.
  - Reset has priority over flush and over both handshakes. Reset asserted mid-transfer discards the held bundle; no flag update and no count occur that cycle.
- Handshake:
  - in_ready = !out_valid | out_ready, combinational. It is forced low while flush=1.
  - Accept occurs on in_valid & in_ready & !flush at the clock edge.
  - Consume occurs on out_valid & out_ready.
  - Single-entry stage; latency from accept to out_valid is 1 cycle. Back-to-back throughput is 1 per cycle while out_ready=1.
- On accept:
  - wb_data←alu_out, wb_addr←rd_addr, wb_en←wb_req, out_valid←1.
  - br_taken←is_branch & cond_true, where cond_true is evaluated against the flags value before this edge:
    - BE = Z.
    - BLT = S^V.
    - BLE = Z | (S^V).
    - BNE = !Z.
    - B = 1.
    - 5–7 = 0.
  - If set_cc, flags←alu_cond at the same edge. A compare therefore affects the next accepted branch, never itself.
  - Flags are loaded verbatim. C is held at its last value by the ALU for logical ops; this block does not mask it.
- Consume without accept: out_valid←0; payload registers hold their values.
- Consume with accept in the same cycle: the new bundle replaces the old one; out_valid stays 1.
- Stall (out_valid=1, out_ready=0): all payload registers and flags hold; in_ready=0.
- Flush:
  - Next cycle out_valid=0, wb_en=0, br_taken=0.
  - The incoming instruction is dropped and flags are not updated.
  - A consume coinciding with flush still increments retired, because downstream already took the bundle.
- retired:
  - Increments by 1 on each consume.
  - Holds at 2^CNT_W−1 once reached; no wrap-around.
- in_valid while in_ready=0: upstream must hold its inputs stable; no capture occurs.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n=0 for 2 cycles, release, no traffic.
  - Required: out_valid=0, flags=0000, retired=0, in_ready=1.
- Compare then branch:
  - Stimulus: accept set_cc=1, alu_cond=4'b1000 (S=1, V=0), alu_out=16'hFFFE; next cycle accept is_branch=1, br_cond=1 (BLT).
  - Required: flags=1000 after the first edge; br_taken=1 with out_valid=1.
  - Repeat with br_cond=0 (BE): required br_taken=0.
- Same-edge ordering:
  - Stimulus: flags=0100 (Z=1); accept an instruction with set_cc=1, is_branch=1, br_cond=0, alu_cond=0000.
  - Required: br_taken=1 (old Z used); flags=0000 afterwards.
- Backpressure:
  - Stimulus: accept alu_out=16'h1234, rd_addr=5, wb_req=1; hold out_ready=0 for 3 cycles while in_valid=1 with 16'hABCD.
  - Required: wb_data stays 1234, in_ready=0, flags unchanged.
  - Then raise out_ready: required 1234 consumed, ABCD captured the same edge, retired increments by 1.
- Flush:
  - Stimulus: out_valid=1 and out_ready=0; assert flush with in_valid=1, set_cc=1, alu_cond=1111.
  - Required: next cycle out_valid=0 and flags unchanged.
  - With out_ready=1 during the flush: required retired+1.
- Saturation:
  - Stimulus: CNT_W=4, stream 20 consumed bundles.
  - Required: retired reaches 15 and holds at 15.
